// File: rtl/cmp_pkg.sv
// -----------------------------------------------------------------------------
// cmp_pkg
// Shared types for the compare/count unit: the 16-entry opcode enumeration,
// the control FSM state enumeration and small helper functions used to size
// count fields and classify opcodes.
// -----------------------------------------------------------------------------
package cmp_pkg;

    // Opcode encoding seen on the op port.
    typedef enum logic [3:0] {
        OP_SLT   = 4'd0,
        OP_SLTU  = 4'd1,
        OP_SLTI  = 4'd2,
        OP_SLTIU = 4'd3,
        OP_CLO   = 4'd4,
        OP_CLZ   = 4'd5,
        OP_MOVZ  = 4'd6,
        OP_BGEZ  = 4'd7,
        OP_BEQ   = 4'd8,
        OP_BLTZ  = 4'd9,
        OP_BGTZ  = 4'd10,
        OP_BLEZ  = 4'd11,
        OP_BNE   = 4'd12,
        OP_MOVN  = 4'd13,
        OP_TGE   = 4'd14,
        OP_TLT   = 4'd15
    } op_e;

    // Control FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Bits needed to hold a count in the range 0..width inclusive.
    function automatic int count_width(input int width);
        return $clog2(width + 1);
    endfunction

    // True for the iterative leading-one/zero count operations.
    function automatic logic is_count_op(input logic [3:0] op);
        return (op == OP_CLO) || (op == OP_CLZ);
    endfunction

endpackage

// File: rtl/lead_count_chunk.sv
// -----------------------------------------------------------------------------
// lead_count_chunk
// Combinational leading-match counter for one CHUNK-bit slice.
// Ports:
//   slice     in   CHUNK bits, MSB inspected first
//   pol       in   1: count leading ones, 0: count leading zeros
//   count     out  number of leading bits equal to pol (0..CHUNK)
//   all_match out  every bit of the slice equals pol
// -----------------------------------------------------------------------------
module lead_count_chunk
    import cmp_pkg::*;
#(
    parameter int CHUNK = 8,
    parameter int CW    = count_width(CHUNK)
) (
    input  logic [CHUNK-1:0] slice,
    input  logic             pol,
    output logic [CW-1:0]    count,
    output logic             all_match
);

    logic run_s;

    // Walk from the MSB down, counting until the first bit that differs.
    always_comb begin
        count = '0;
        run_s = 1'b1;
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (run_s && (slice[i] == pol)) begin
                count = count + CW'(1);
            end else begin
                run_s = 1'b0;
            end
        end
        all_match = (count == CW'(CHUNK));
    end

endmodule

// File: rtl/compare_count_unit.sv
// -----------------------------------------------------------------------------
// compare_count_unit
// Sequential MIPS compare / count / conditional-move / branch-test unit.
// Single-cycle ops go IDLE->DONE; CLO/CLZ go IDLE->SCAN and inspect CHUNK bits
// of the operand per cycle (MSB chunk first) until a chunk does not fully
// match or the last chunk has been inspected.
//
// Optional feature: define CMP_TRAP_EN to drive trap = cond for ops
// BEQ/TEQ, BNE/TNE, TGE(U), TLT(U). Without it trap is held at 0.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   in_valid/in_ready   request handshake (ready only in IDLE, not in reset)
//   op, uns, a, b       opcode, unsigned-compare select, rs and rt operands
//   out_valid/out_ready result handshake; outputs held until accepted
//   result, wr_en       write-back value and enable
//   cond, trap          branch/move condition and trap request
// -----------------------------------------------------------------------------
module compare_count_unit
    import cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic             uns,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             wr_en,
    output logic             cond,
    output logic             trap
);

    localparam int CNTW   = count_width(WIDTH);
    localparam int CCW    = count_width(CHUNK);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    state_e            state_r;
    state_e            next_s;
    logic              accept_s;

    // Count datapath: operand is shifted left so the chunk under test is
    // always the top CHUNK bits.
    logic [WIDTH-1:0]  shift_r;
    logic              pol_r;
    logic [IDXW-1:0]   idx_r;
    logic [CNTW-1:0]   cnt_r;
    logic [CCW-1:0]    lc_count_s;
    logic              lc_all_s;
    logic              last_s;
    logic [CNTW-1:0]   scan_total_s;

    // Single-cycle evaluation of the incoming request.
    logic [WIDTH-1:0]  ev_result_s;
    logic              ev_wr_s;
    logic              ev_cond_s;
    logic              ev_trap_s;
    logic              lts_s;
    logic              ltu_s;
    logic              eq_s;
    logic              a_neg_s;
    logic              a_zero_s;
    logic              b_zero_s;

    logic [WIDTH-1:0]  result_r;
    logic              wr_en_r;
    logic              cond_r;
    logic              trap_r;

    assign accept_s = in_valid & in_ready;

    lead_count_chunk #(
        .CHUNK (CHUNK),
        .CW    (CCW)
    ) u_lcc (
        .slice     (shift_r[WIDTH-1 -: CHUNK]),
        .pol       (pol_r),
        .count     (lc_count_s),
        .all_match (lc_all_s)
    );

    // Scan bookkeeping: last-chunk flag and running total including this chunk.
    always_comb begin
        last_s       = (idx_r == IDXW'(NCHUNK - 1));
        scan_total_s = cnt_r + CNTW'(lc_count_s);
    end

    // Primitive comparisons on the live request operands.
    always_comb begin
        lts_s    = $signed(a) < $signed(b);
        ltu_s    = a < b;
        eq_s     = (a == b);
        a_neg_s  = a[WIDTH-1];
        a_zero_s = (a == '0);
        b_zero_s = (b == '0);
    end

    // Per-opcode result, write enable and condition for single-cycle ops.
    always_comb begin
        ev_result_s = '0;
        ev_wr_s     = 1'b0;
        ev_cond_s   = 1'b0;
        case (op_e'(op))
            OP_SLT, OP_SLTI: begin
                ev_cond_s   = lts_s;
                ev_result_s = WIDTH'(lts_s);
                ev_wr_s     = 1'b1;
            end
            OP_SLTU, OP_SLTIU: begin
                ev_cond_s   = ltu_s;
                ev_result_s = WIDTH'(ltu_s);
                ev_wr_s     = 1'b1;
            end
            OP_MOVZ: begin
                ev_cond_s   = b_zero_s;
                ev_result_s = a;
                ev_wr_s     = b_zero_s;
            end
            OP_MOVN: begin
                ev_cond_s   = ~b_zero_s;
                ev_result_s = a;
                ev_wr_s     = ~b_zero_s;
            end
            OP_BGEZ: ev_cond_s = ~a_neg_s;
            OP_BLTZ: ev_cond_s = a_neg_s;
            OP_BGTZ: ev_cond_s = ~a_neg_s & ~a_zero_s;
            OP_BLEZ: ev_cond_s = a_neg_s | a_zero_s;
            OP_BEQ:  ev_cond_s = eq_s;
            OP_BNE:  ev_cond_s = ~eq_s;
            OP_TGE:  ev_cond_s = uns ? ~ltu_s : ~lts_s;
            OP_TLT:  ev_cond_s = uns ? ltu_s : lts_s;
            OP_CLO, OP_CLZ: ev_wr_s = 1'b1;
            default: begin
                ev_result_s = '0;
                ev_wr_s     = 1'b0;
                ev_cond_s   = 1'b0;
            end
        endcase
    end

    // Trap request: condition of the trap-capable ops, or constant 0.
    always_comb begin
        ev_trap_s = 1'b0;
`ifdef CMP_TRAP_EN
        case (op_e'(op))
            OP_BEQ, OP_BNE, OP_TGE, OP_TLT: ev_trap_s = ev_cond_s;
            default:                        ev_trap_s = 1'b0;
        endcase
`else
        ev_trap_s = 1'b0;
`endif
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    next_s = is_count_op(op) ? ST_SCAN : ST_DONE;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (lc_all_s && !last_s) begin
                    next_s = ST_SCAN;
                end else begin
                    next_s = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    next_s = ST_IDLE;
                end else begin
                    next_s = ST_DONE;
                end
            end
            default: next_s = ST_IDLE;
        endcase
    end

    // FSM handshake outputs decoded from the state register.
    always_comb begin
        in_ready  = (state_r == ST_IDLE) & ~reset;
        out_valid = (state_r == ST_DONE);
    end

    // Operand capture, chunk scan and result registers (loaded on DONE entry).
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_r  <= '0;
            pol_r    <= 1'b0;
            idx_r    <= '0;
            cnt_r    <= '0;
            result_r <= '0;
            wr_en_r  <= 1'b0;
            cond_r   <= 1'b0;
            trap_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        shift_r <= a;
                        pol_r   <= (op == OP_CLO);
                        idx_r   <= '0;
                        cnt_r   <= '0;
                        if (!is_count_op(op)) begin
                            result_r <= ev_result_s;
                            wr_en_r  <= ev_wr_s;
                            cond_r   <= ev_cond_s;
                            trap_r   <= ev_trap_s;
                        end
                    end
                end
                ST_SCAN: begin
                    if (lc_all_s && !last_s) begin
                        shift_r <= shift_r << CHUNK;
                        idx_r   <= idx_r + IDXW'(1);
                        cnt_r   <= scan_total_s;
                    end else begin
                        result_r <= WIDTH'(scan_total_s);
                        wr_en_r  <= 1'b1;
                        cond_r   <= 1'b0;
                        trap_r   <= 1'b0;
                    end
                end
                ST_DONE: begin
                    // Trap is a one-shot request: drop it once the result is taken.
                    if (out_ready) begin
                        trap_r <= 1'b0;
                    end
                end
                default: begin
                    trap_r <= 1'b0;
                end
            endcase
        end
    end

    assign result = result_r;
    assign wr_en  = wr_en_r;
    assign cond   = cond_r;
    assign trap   = trap_r;

endmodule
